// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - pipeline hazard control signal bundle
interface hazard_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_uses_rt;
    logic        ID_EX_mem_read;
    logic [4:0]  ID_EX_rt;
    logic        branch_taken;
    logic        md_start;
    logic        ID_reads_hilo;
    logic        pc_write;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cnt;

    modport master (
        output ID_rs, ID_rt, ID_uses_rt, ID_EX_mem_read, ID_EX_rt,
               branch_taken, md_start, ID_reads_hilo,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               md_busy, md_done, stall_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rt, ID_EX_mem_read, ID_EX_rt,
               branch_taken, md_start, ID_reads_hilo,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               md_busy, md_done, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / mult-div hazard detection and pipeline stall control
module hazard_ctrl #(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);
    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic md_hazard;
    logic stall;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic md_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            md_cnt_q    <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        load_use    = hz.ID_EX_mem_read && (hz.ID_EX_rt != 5'd0) &&
                      ((hz.ID_EX_rt == hz.ID_rs) ||
                       (hz.ID_uses_rt && (hz.ID_EX_rt == hz.ID_rt)));
        md_hazard   = (state_q == MD_BUSY) && (hz.ID_reads_hilo || hz.md_start);
        stall       = load_use || md_hazard;
        md_done     = (state_q == MD_BUSY) && (md_cnt_q == 8'd0);

        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;

        // The counter runs regardless of stalls; only acceptance of a new start is stall-gated.
        case (state_q)
            RUN: begin
                if (hz.md_start && !stall) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        // Reset holds the front end frozen with a bubble going into EX.
        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            pc_write    = !stall;
            if_id_write = !stall;
            if_id_flush = !stall && hz.branch_taken;
            id_ex_flush = stall;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.IF_ID_write = if_id_write;
    assign hz.IF_ID_flush = if_id_flush;
    assign hz.ID_EX_flush = id_ex_flush;
    assign hz.md_busy     = (state_q == MD_BUSY);
    assign hz.md_done     = md_done;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int MD = 4;

    logic clk = 1'b1;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_if hif();

    hazard_ctrl #(.MD_CYCLES(MD)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    logic [21:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_busy_left  = 0;
    int m_stall_cnt  = 0;

    always @(negedge clk) begin
        logic [21:0] act;
        logic [21:0] exp;
        cyc++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {hif.pc_write, hif.IF_ID_write, hif.IF_ID_flush, hif.ID_EX_flush,
                   hif.md_busy, hif.md_done, hif.stall_cnt};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL outputs cycle=%0d got pcw,ifw,iff,exf,busy,done,cnt=%b %b %b %b %b %b %h expected=%b %b %b %b %b %b %h",
                         cyc, act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                         exp[21], exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
            end
        end
    end

    task automatic cycle(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic mr, input logic [4:0] ert,
                         input logic br, input logic ms, input logic hl);
        logic busy, lu, mdh, st;
        logic [15:0] sc;
        rst                = r;
        hif.ID_rs          = rs;
        hif.ID_rt          = rt;
        hif.ID_uses_rt     = urt;
        hif.ID_EX_mem_read = mr;
        hif.ID_EX_rt       = ert;
        hif.branch_taken   = br;
        hif.md_start       = ms;
        hif.ID_reads_hilo  = hl;
        if (r) begin
            m_busy_left = 0;
            m_stall_cnt = 0;
            exp_q.push_back({6'b000100, 16'h0000});
            @(posedge clk);
            #1;
        end else begin
            busy = (m_busy_left > 0);
            lu   = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
            mdh  = busy && (hl || ms);
            st   = lu || mdh;
            sc   = 16'(m_stall_cnt);
            exp_q.push_back({!st, !st, !st && br, st, busy, (m_busy_left == 1), sc});
            @(posedge clk);
            #1;
            if (st && m_stall_cnt < 65535) m_stall_cnt++;
            if (busy) m_busy_left--;
            else if (ms && !st) m_busy_left = MD;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // load-use on rs, then EX destination r0 never hazards
        cycle(0, 8, 3, 0, 1, 8, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0, 0, 0);
        cycle(0, 2, 9, 1, 1, 9, 0, 0, 0);
        cycle(0, 2, 9, 0, 1, 9, 0, 0, 0);

        // taken branch with and without a simultaneous load-use
        cycle(0, 1, 2, 1, 0, 0, 1, 0, 0);
        cycle(0, 5, 2, 1, 1, 5, 1, 0, 0);

        // mult followed by mfhi held until it proceeds
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MD + 1; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // back-to-back start: held through the busy window, then accepted
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MD + 1; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(MD + 1);

        // reset in the middle of a busy window, then a full restart
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(MD + 1);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end

        // saturation of the stall counter
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) cycle(0, 7, 0, 0, 1, 7, 0, 0, 0);
        idle(2);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 32: busy duration of the multi-cycle mult/div unit in cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 ID_rs, ID_rt  input  5 each  source register fields of the instruction in ID.
REQ-005 ID_uses_rt  input  1  instruction in ID reads rt as an operand.
REQ-006 ID_EX_mem_read, ID_EX_rt  input  1, 5  instruction in EX is a load, and its destination register.
REQ-007 branch_taken  input  1  branch or jump resolved taken in ID this cycle.
REQ-008 md_start  input  1  instruction in ID is mult/div.
REQ-009 ID_reads_hilo  input  1  instruction in ID is mfhi/mflo.
REQ-010 pc_write, IF_ID_write  output  1 each  PC and IF/ID register update enables.
REQ-011 IF_ID_flush, ID_EX_flush  output  1 each  zero IF/ID; insert a bubble into ID/EX.
REQ-012 md_busy, md_done  output  1 each  mult/div in progress; last busy cycle.
REQ-013 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-014 States SHALL be RUN and MD_BUSY, held with an 8-bit down-counter md_cnt.
REQ-015 Outputs pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush and md_done SHALL be combinational from the registered state and the current inputs.
REQ-016 load_use SHALL be ID_EX_mem_read && ID_EX_rt!=0 && (ID_EX_rt==ID_rs || (ID_uses_rt && ID_EX_rt==ID_rt)).
REQ-017 md_hazard SHALL be (state==MD_BUSY) && (ID_reads_hilo || md_start).
REQ-018 stall SHALL be load_use || md_hazard.
REQ-019 When stall=1: pc_write=0, IF_ID_write=0, ID_EX_flush=1 and IF_ID_flush=0 (a stall overrides branch_taken).
REQ-020 When stall=0: pc_write=1, IF_ID_write=1, ID_EX_flush=0, and IF_ID_flush=branch_taken.
REQ-021 RUN->MD_BUSY SHALL occur at the edge ending a cycle with md_start=1 and stall=0, loading md_cnt=MD_CYCLES-1.
REQ-022 In MD_BUSY, md_cnt SHALL decrement each cycle.
REQ-023 md_done SHALL equal (state==MD_BUSY && md_cnt==0); the next edge returns the state to RUN.
REQ-024 md_start arriving while in MD_BUSY SHALL stall; it is accepted in the first RUN cycle.
REQ-025 md_busy SHALL be 1 iff state==MD_BUSY, giving exactly MD_CYCLES busy cycles per accepted start.
REQ-026 A stalled mfhi/mflo SHALL proceed in the first cycle after md_done.
REQ-027 stall_cnt SHALL increment at every edge where stall=1 and saturate at 16'hFFFF.
REQ-028 A load-use stall during MD_BUSY SHALL NOT affect md_cnt.

Reset
REQ-029 While rst=1: state=RUN, md_cnt=0, md_busy=0, md_done=0, stall_cnt=0, pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_flush=1.
REQ-030 Reset asserted mid-MD_BUSY SHALL abort the operation immediately, with no md_done pulse.
REQ-031 The first edge after rst deasserts SHALL evaluate in RUN.

Verification
REQ-032 Load-use: ID_EX_mem_read=1, ID_EX_rt=8, ID_rs=8 -> one cycle pc_write=0, IF_ID_write=0, ID_EX_flush=1, stall_cnt=1; with ID_EX_rt=0 -> no stall.
REQ-033 Branch: branch_taken=1, no hazard -> IF_ID_flush=1, pc_write=1; with load_use simultaneously -> IF_ID_flush=0, stall asserted.
REQ-034 Mult then mfhi, MD_CYCLES=4: md_start accepted at cycle T -> md_busy in T+1..T+4, md_done in T+4 only; ID_reads_hilo held -> stalled T+1..T+4, proceeds at T+5, stall_cnt=4.
REQ-035 Back-to-back md_start during MD_BUSY -> stalled until RUN, then accepted; second busy window exactly MD_CYCLES cycles.
REQ-036 rst pulsed at md_cnt=2 -> md_busy=0 immediately, no md_done, stall_cnt=0; the next md_start restarts the full count.
REQ-037 Force 65540 stall cycles -> stall_cnt holds 16'hFFFF.
